hilo_muldiv_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit with the architectural HI/LO register pair for the multicycle MIPS core.
- Executes MULT, MULTU, DIV, DIVU over a fixed number of cycles and handles MTHI/MTLO writes.
- Presents the selected HI or LO value on `hilo_out`. `hilo_out` feeds the GPR write-data selector for MFHI/MFLO.
- The main controller stalls on `busy`.

---
 rtl/hilo_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit
// owning the architectural HI/LO register pair.
module hilo_muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hilo_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic [31:0] a_raw_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [1:0]  op_q;
  logic        sa_q;
  logic        sb_q;
  logic        busy_q;
  logic        done_q;

  logic        sa_in;
  logic        sb_in;
  logic [31:0] ma_in;
  logic [31:0] mb_in;

  logic [32:0] add_s;
  logic [32:0] trial;
  logic [32:0] sub_s;
  logic        ge;
  logic [31:0] rem_n;
  logic [63:0] acc_d;

  logic        neg;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // Operand capture: signed ops work on magnitudes, unsigned ops as-is.
  always_comb begin
    sa_in = ~op[0] & a[31];
    sb_in = ~op[0] & b[31];
    ma_in = sa_in ? -a : a;
    mb_in = sb_in ? -b : b;
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    add_s = {1'b0, acc_q[63:32]}
          + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    trial = {acc_q[63:32], acc_q[31]};
    sub_s = trial - {1'b0, opnd_q};
    ge    = trial >= {1'b0, opnd_q};
    rem_n = ge ? sub_s[31:0] : trial[31:0];
    if (op_q[1])
      acc_d = {rem_n, acc_q[30:0], ge};
    else
      acc_d = {add_s, acc_q[31:1]};
  end

  // Sign correction and divide-by-zero result for the final write.
  always_comb begin
    neg  = sa_q ^ sb_q;
    prod = neg ? -acc_q : acc_q;
    quo  = neg ? -acc_q[31:0] : acc_q[31:0];
    rem  = sa_q ? -acc_q[63:32] : acc_q[63:32];
    hi_d = prod[63:32];
    lo_d = prod[31:0];
    if (op_q[1]) begin
      if (opnd_q == 32'd0) begin
        hi_d = a_raw_q;
        lo_d = 32'hFFFF_FFFF;
      end else begin
        hi_d = rem;
        lo_d = quo;
      end
    end
  end

  // Control FSM, datapath registers and HI/LO update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_raw_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q    <= op;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            a_raw_q <= a;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
            if (op[1]) begin
              opnd_q <= mb_in;
              acc_q  <= {32'd0, ma_in};
            end else begin
              opnd_q <= ma_in;
              acc_q  <= {32'd0, mb_in};
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1))
            state_q <= FIN;
        end
        FIN: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hilo_out = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors for the HI/LO
// multiply/divide unit with hand-computed results.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        hilo_sel;
  logic        busy;
  logic        done;
  logic [31:0] hilo_out;

  int n_chk;
  int n_pass;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  hilo_muldiv_unit #(.ITER(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .hilo_sel (hilo_sel),
    .busy     (busy),
    .done     (done),
    .hilo_out (hilo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h",
                  tag, got, exp);
  endtask

  task automatic read_hilo(input string tag,
                           input logic [31:0] hi_e,
                           input logic [31:0] lo_e);
    hilo_sel = 1'b1;
    #1 check({tag, "_hi"}, hilo_out, hi_e);
    hilo_sel = 1'b0;
    #1 check({tag, "_lo"}, hilo_out, lo_e);
  endtask

  task automatic launch(input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish(input string tag,
                        input int used,
                        input logic [31:0] hi_e,
                        input logic [31:0] lo_e);
    int n;
    n = used;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_cyc"}, 32'(n), 32'd33);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    read_hilo(tag, hi_e, lo_e);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input string tag,
                     input logic [1:0] o,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] hi_e,
                     input logic [31:0] lo_e);
    launch(o, x, y);
    finish(tag, 0, hi_e, lo_e);
  endtask

  initial begin
    int dn;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    hilo_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    read_hilo("rst", 32'h0, 32'h0);

    run("mult_neg", MULT, 32'hFFFF_FFFD, 32'd5,
        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 32'h0000_0001);
    run("mult_m1", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0, 32'h1);
    run("div_neg", DIV, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run("divu_z", DIVU, 32'd100, 32'd0,
        32'h0000_0064, 32'hFFFF_FFFF);
    run("div_z", DIV, 32'hFFFF_FFF9, 32'd0,
        32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h0, 32'h8000_0000);

    // MTHI then MTLO in IDLE
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    read_hilo("mthi", 32'h1234_5678, 32'h8000_0000);
    lo_we = 1'b1;
    wdata = 32'hCAFE_0001;
    @(negedge clk);
    lo_we = 1'b0;
    read_hilo("mtlo", 32'h1234_5678, 32'hCAFE_0001);

    // start and write strobes during a running MULT
    launch(MULT, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op = DIVU;
    a = 32'd100;
    b = 32'd7;
    hi_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    read_hilo("old", 32'h1234_5678, 32'hCAFE_0001);
    finish("mult_ign", 5, 32'h0, 32'd42);
    repeat (3) @(negedge clk);
    check("no_queue", {31'd0, busy}, 32'd0);

    // reset mid-DIVU
    launch(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1 check("arst_busy", {31'd0, busy}, 32'd0);
    read_hilo("arst", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("arst_quiet", 32'(dn), 32'd0);

    run("restart", MULTU, 32'd6, 32'd7, 32'h0, 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
